// File: rtl/platformniossdram_key_event_ctrl_if.sv
// Avalon-MM register port of the key event controller.
// The host CPU side uses the master modport. The controller uses the slave modport.
interface platformniossdram_key_event_ctrl_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/platformniossdram_key_event_ctrl.sv
// Debounced key controller for the Nios II bus.
// Each of the 8 raw keys is synchronized and debounced. Debounced transitions
// are queued as events in a small FIFO. A level interrupt is raised while
// events are pending and the interrupt is enabled.
//
// Register map:
//   0 STATE  (RO)           : debounced key levels db[7:0]
//   1 EVENT  (RO, pops)     : bit31 valid, bit8 dir, bits2:0 idx
//   2 CTRL   (RW)           : bit0 irq_en, bit1 fifo_clr (self-clearing)
//   3 STATUS (RO / W1C)     : bits4:0 count, bit8 overflow (write 1 to clear)
//
// Build option RELEASE_EVENTS_EN:
//   - Defined: both press and release transitions are queued as events.
//   - Undefined: only presses are queued. STATE still tracks releases.
module platformniossdram_key_event_ctrl #(
  parameter int TICK_DIV   = 50000,
  parameter int DB_TICKS   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  platformniossdram_key_event_ctrl_if.slave      avs,
  input  logic [7:0]                             in_port,
  output logic                                   irq
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Input synchronizer
  logic [7:0]    sync_q1;
  logic [7:0]    key_sync;

  // Debounce tick prescaler
  logic [PW-1:0] presc;
  logic          tick;

  // Debounce state
  logic [7:0]    db;
  logic [3:0]    stab_cnt [8];
  logic [7:0]    flip;
  logic [7:0]    pend;
  logic [7:0]    pend_set;
  logic [7:0]    pend_clr;

  // Event encoder
  logic          push;
  logic [2:0]    push_idx;
  logic [3:0]    push_entry;

  // Event FIFO. Each entry is {dir, idx}.
  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_ok;
  logic          ovf_set;
  logic          pop;
  logic [3:0]    head;

  // Register-side controls
  logic          overflow;
  logic          irq_en;
  logic          wr_ctrl;
  logic          wr_status;
  logic          fifo_clr;
  logic          ovf_clr;
  logic          rd_event;
  logic [31:0]   rd_mux;
  logic          unused_wd;

  // Two-flop synchronizer on the asynchronous key pins
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1  <= '0;
      key_sync <= '0;
    end else begin
      sync_q1  <= in_port;
      key_sync <= sync_q1;
    end
  end

  // Prescaler counting 0..TICK_DIV-1. tick is high for the wrap cycle.
  always_comb begin
    tick = (presc == PW'(TICK_DIV - 1));
  end

  // Advance the prescaler and wrap it on tick
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // A key flips on the tick that completes DB_TICKS stable ticks of disagreement
  always_comb begin
    flip = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (tick && (key_sync[i] != db[i]) && (stab_cnt[i] == 4'(DB_TICKS - 1))) begin
        flip[i] = 1'b1;
      end
    end
  end

  // Update the per-key stability counters and the debounced levels
  always_ff @(posedge clk) begin
    if (reset) begin
      db <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        stab_cnt[i] <= '0;
      end
    end else begin
      db <= db ^ flip;
      for (int unsigned i = 0; i < 8; i++) begin
        if (key_sync[i] == db[i] || flip[i]) begin
          stab_cnt[i] <= '0;
        end else if (tick) begin
          stab_cnt[i] <= stab_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Select which transitions raise a pending event
  always_comb begin
`ifdef RELEASE_EVENTS_EN
    pend_set = flip;
`else
    // Only 0 -> 1 transitions (presses) are reported.
    pend_set = flip & ~db;
`endif
  end

  // Pick the lowest-index pending key. At most one event is pushed per cycle.
  always_comb begin
    push     = 1'b0;
    push_idx = '0;
    pend_clr = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!push && pend[i]) begin
        push        = 1'b1;
        push_idx    = 3'(i);
        pend_clr[i] = 1'b1;
      end
    end
    push_entry = {db[push_idx], push_idx};
  end

  // Track pending keys. Newly flipped keys take priority over the bit being drained.
  always_ff @(posedge clk) begin
    if (reset || fifo_clr) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
    end
  end

  // Decode register writes and the event pop
  always_comb begin
    wr_ctrl    = avs.write && (avs.address == 2'd2);
    wr_status  = avs.write && (avs.address == 2'd3);
    fifo_clr   = wr_ctrl && avs.writedata[1];
    ovf_clr    = wr_status && avs.writedata[8];
    rd_event   = avs.read && (avs.address == 2'd1);
    fifo_full  = (count == 5'(FIFO_DEPTH));
    fifo_empty = (count == 5'd0);
    // A clear discards this cycle's push and overrides a coincident pop.
    push_ok    = push && !fifo_full && !fifo_clr;
    ovf_set    = push && fifo_full && !fifo_clr;
    pop        = rd_event && !fifo_empty && !fifo_clr;
    head       = fifo_mem[rd_ptr];
    unused_wd  = ^{avs.writedata[31:9], avs.writedata[7:2]};
  end

  // Store pushed events into the FIFO storage (no reset needed)
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // Maintain the FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset || fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag. A new overflow wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Hold the interrupt enable bit of CTRL
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en <= avs.writedata[0];
    end
  end

  // Read mux sees pre-write state, so a coincident write does not affect the value returned
  always_comb begin
    rd_mux = '0;
    case (avs.address)
      2'd0: rd_mux[7:0] = db;
      2'd1: begin
        if (!fifo_empty) begin
          rd_mux[31]  = 1'b1;
          rd_mux[8]   = head[3];
          rd_mux[2:0] = head[2:0];
        end
      end
      2'd2: rd_mux[0] = irq_en;
      2'd3: begin
        rd_mux[8]   = overflow;
        rd_mux[4:0] = count;
      end
      default: rd_mux = '0;
    endcase
  end

  // Register the read data and hold it until the next read
  always_ff @(posedge clk) begin
    if (reset) begin
      avs.readdata <= '0;
    end else if (avs.read) begin
      avs.readdata <= rd_mux;
    end
  end

  // Register the level interrupt from the enable bit and FIFO occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en && !fifo_empty;
    end
  end

endmodule

// File: tb/tb_platformniossdram_key_event_ctrl.sv
// Testbench for platformniossdram_key_event_ctrl.
// A transaction-level reference model runs alongside the DUT. It keeps a
// timestamp per key for debounce and a queue for events. readdata and irq are
// compared against the model on every cycle. Directed sequences add literal
// expectations, and randomized key and bus traffic follows them.
// The macro RELEASE_EVENTS_EN selects the release-event variant.
module tb_platformniossdram_key_event_ctrl;
  localparam int TICK_DIV   = 16;
  localparam int DB_TICKS   = 4;
  localparam int FIFO_DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_port;
  logic       irq;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  platformniossdram_key_event_ctrl_if bus ();

  platformniossdram_key_event_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DB_TICKS   (DB_TICKS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .avs     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  m_d1, m_d2, m_db, m_pend;
  int          m_start [8];
  int          m_cyc;
  logic [3:0]  m_fifo [$];
  logic        m_ovf, m_irq_en, m_irq;
  logic [31:0] m_rd;

  always @(posedge clk) begin : model
    logic [7:0] flip, newp, pclr;
    logic       tick, push, full, clr, pop, ovf_clr;
    logic [3:0] ent;
    if (reset) begin
      m_d1 = '0; m_d2 = '0; m_db = '0; m_pend = '0;
      for (int i = 0; i < 8; i++) m_start[i] = -1;
      m_cyc = 0; m_fifo.delete();
      m_ovf = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0; m_rd = '0;
    end else begin
      tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
      // A key flips once DB_TICKS ticks have elapsed during an unbroken disagreement.
      flip = '0;
      for (int i = 0; i < 8; i++) begin
        if (m_d2[i] == m_db[i]) m_start[i] = -1;
        else begin
          if (m_start[i] < 0) m_start[i] = m_cyc;
          if (tick && ((m_cyc + 1) / TICK_DIV - m_start[i] / TICK_DIV) >= DB_TICKS) begin
            flip[i] = 1'b1;
            m_start[i] = -1;
          end
        end
      end
`ifdef RELEASE_EVENTS_EN
      newp = flip;
`else
      newp = flip & ~m_db;
`endif
      push = 1'b0; ent = '0; pclr = '0;
      for (int i = 0; i < 8; i++)
        if (!push && m_pend[i]) begin
          push = 1'b1; pclr[i] = 1'b1; ent = {m_db[i], 3'(i)};
        end
      clr     = bus.write && bus.address == 2'd2 && bus.writedata[1];
      ovf_clr = bus.write && bus.address == 2'd3 && bus.writedata[8];
      full    = (m_fifo.size() == FIFO_DEPTH);
      pop     = bus.read && bus.address == 2'd1 && m_fifo.size() > 0 && !clr;
      if (bus.read) begin
        case (bus.address)
          2'd0: m_rd = 32'(m_db);
          2'd1: m_rd = (m_fifo.size() > 0) ?
                  32'h8000_0000 + 32'(m_fifo[0][3]) * 256 + 32'(m_fifo[0][2:0]) : 32'd0;
          2'd2: m_rd = 32'(m_irq_en);
          default: m_rd = 32'(m_ovf) * 256 + 32'(m_fifo.size());
        endcase
      end
      m_irq = m_irq_en && (m_fifo.size() > 0);
      if (bus.write && bus.address == 2'd2) m_irq_en = bus.writedata[0];
      if (push && full && !clr) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (clr) begin
        m_fifo.delete();
        m_pend = '0;
      end else begin
        if (pop) void'(m_fifo.pop_front());
        if (push && !full) m_fifo.push_back(ent);
        m_pend = (m_pend & ~pclr) | newp;
      end
      m_db  = m_db ^ flip;
      m_d2  = m_d1;
      m_d1  = in_port;
      m_cyc = m_cyc + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (bus.readdata !== m_rd) begin
        miscompares++;
        $display("FAIL readdata @%0t: got %h expected %h", $time, bus.readdata, m_rd);
      end
      vectors++;
      if (irq !== m_irq) begin
        miscompares++;
        $display("FAIL irq @%0t: got %b expected %b", $time, irq, m_irq);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus cycle, started and ended at a falling edge.
  task automatic cyc_bus(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d);
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    cyc_bus(1'b1, 1'b0, a, '0);
    lit(nm, bus.readdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  keys;
    logic [1:0]  a;
    logic [31:0] wd;
    logic        r, w;
    int          guard, b;
    reset = 1'b1; in_port = '0;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
    idle(3);
    chk_en = 1'b1;
    lit("reset_readdata", bus.readdata, 32'h0);
    lit("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;

    // Debounce of one key
    in_port = 8'h01;
    idle(70);
    rd_chk("state_key0", 2'd0, 32'h0000_0001);
    rd_chk("event_key0", 2'd1, 32'h8000_0100);
    rd_chk("status_empty", 2'd3, 32'h0);

    // Bounce rejection on key 3
    for (int k = 0; k < 25; k++) begin
      in_port = in_port ^ 8'h08;
      idle(20);
    end
    in_port = 8'h01;
    idle(80);
    rd_chk("bounce_state", 2'd0, 32'h0000_0001);
    rd_chk("bounce_count", 2'd3, 32'h0);

    // Simultaneous press of keys 0 and 7
    in_port = 8'h00;
    idle(80);
    cyc_bus(1'b0, 1'b1, 2'd2, 32'h2);
    in_port = 8'h81;
    idle(80);
    rd_chk("simul_ev0", 2'd1, 32'h8000_0100);
    rd_chk("simul_ev7", 2'd1, 32'h8000_0107);
    rd_chk("simul_empty", 2'd1, 32'h0);
    in_port = 8'h00;
    idle(80);
`ifdef RELEASE_EVENTS_EN
    rd_chk("release_ev0", 2'd1, 32'h8000_0000);
    rd_chk("release_ev7", 2'd1, 32'h8000_0007);
`else
    rd_chk("release_none", 2'd1, 32'h0);
`endif

    // Overflow and clear
    cyc_bus(1'b0, 1'b1, 2'd2, 32'h2);
    in_port = 8'hFF; idle(80);
    in_port = 8'h00; idle(80);
    in_port = 8'h01; idle(80);
    rd_chk("ovf_status", 2'd3, 32'h0000_0108);
    cyc_bus(1'b0, 1'b1, 2'd3, 32'h100);
    rd_chk("ovf_cleared", 2'd3, 32'h0000_0008);
    cyc_bus(1'b0, 1'b1, 2'd2, 32'h2);
    rd_chk("clr_count", 2'd3, 32'h0);
    rd_chk("clr_event", 2'd1, 32'h0);

    // Interrupt behaviour
    in_port = 8'h03; idle(80);
    cyc_bus(1'b0, 1'b1, 2'd2, 32'h1);
    lit("irq_not_yet", {31'b0, irq}, 32'h0);
    idle(1);
    lit("irq_set", {31'b0, irq}, 32'h1);
    in_port = 8'h07;
    guard = 0;
    while (m_pend == 8'h00 && guard < 200) begin
      idle(1);
      guard++;
    end
    lit("pend_wait_timeout", 32'(guard < 200), 32'h1);
    rd_chk("pushpop_ev", 2'd1, 32'h8000_0101);
    lit("pushpop_irq", {31'b0, irq}, 32'h1);
    rd_chk("pushpop_count", 2'd3, 32'h1);
    lit("pushpop_irq2", {31'b0, irq}, 32'h1);
    rd_chk("pop_last", 2'd1, 32'h8000_0102);
    lit("irq_lag", {31'b0, irq}, 32'h1);
    idle(1);
    lit("irq_clear", {31'b0, irq}, 32'h0);

    // Reset mid-operation with three events queued
    in_port = 8'h00; idle(80);
    cyc_bus(1'b0, 1'b1, 2'd2, 32'h3);
    in_port = 8'h07; idle(80);
    rd_chk("three_queued", 2'd3, 32'h3);
    reset = 1'b1;
    idle(1);
    lit("midrst_readdata", bus.readdata, 32'h0);
    lit("midrst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    rd_chk("midrst_count", 2'd3, 32'h0);
    rd_chk("midrst_state", 2'd0, 32'h0);
    idle(80);
    rd_chk("rereport_ev0", 2'd1, 32'h8000_0100);

    // Randomized key and bus traffic
    keys = in_port;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(39) == 0) keys = 8'($urandom);
      else if ($urandom_range(29) == 0) begin
        b = int'($urandom_range(7));
        keys[b] = ~keys[b];
      end
      in_port = keys;
      r = ($urandom_range(3) == 0);
      w = ($urandom_range(15) == 0);
      a = 2'($urandom_range(3));
      wd = $urandom;
      if (a == 2'd2) wd[1] = ($urandom_range(7) == 0);
      cyc_bus(r, w, a, wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
